// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the writeback stage (A) and buffered multicycle results (B) onto the register file write port
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [4:0]       a_addr,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_addr,
    input  logic [31:0]      b_data,
    output logic             we3,
    output logic [4:0]       a3,
    output logic [31:0]      wd3,
    output logic [31:0]      busy_mask,
    output logic [PTR_W:0]   fifo_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             we3_q, we3_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic             a_win, do_enq, do_pop, head_live;
    logic [31:0]      busy;

    // Arbitration: a real A write always wins; B pops only when A is idle or targets r0
    always_comb begin
        a_win     = a_valid && (a_addr != 5'd0);
        b_ready   = (count_q != FULL_CNT);
        do_enq    = b_valid && b_ready && (b_addr != 5'd0);
        do_pop    = !a_win && (count_q != '0);
        head_live = live_q[rd_ptr_q];
    end

    // FIFO next state: squash stale B results behind a newer A write, clear popped slot, fill tail
    always_comb begin
        live_d = live_q;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_win && addr_q[i] == a_addr) live_d[i] = 1'b0;
        end
        if (do_pop) live_d[rd_ptr_q] = 1'b0;
        if (do_enq) begin
            live_d[wr_ptr_q] = !(a_win && b_addr == a_addr);
            addr_d[wr_ptr_q] = b_addr;
            data_d[wr_ptr_q] = b_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W + 1)'(do_enq) - (PTR_W + 1)'(do_pop);
    end

    // Write port next state: A, else a live popped head, else hold address/data with we3 low
    always_comb begin
        we3_d = a_win || (do_pop && head_live);
        a3_d  = a_win ? a_addr : (do_pop && head_live) ? addr_q[rd_ptr_q] : a3_q;
        wd3_d = a_win ? a_data : (do_pop && head_live) ? data_q[rd_ptr_q] : wd3_q;
    end

    // Pending-write mask for the hazard unit, built from live entries only
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) busy[addr_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    // State registers; reset discards every queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign we3        = we3_q;
    assign a3         = a3_q;
    assign wd3        = wd3_q;
    assign busy_mask  = busy;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenario tests for the register file write arbiter
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    wb_write_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we3(we3), .a3(a3), .wd3(wd3), .busy_mask(busy_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total_cnt++; if (we3 !== 1'b0) $display("FAIL rst_we3 got %0h exp 0", we3); else pass_cnt++;
        total_cnt++; if (a3 !== 5'd0) $display("FAIL rst_a3 got %0h exp 0", a3); else pass_cnt++;
        total_cnt++; if (wd3 !== 32'd0) $display("FAIL rst_wd3 got %0h exp 0", wd3); else pass_cnt++;
        total_cnt++; if (b_ready !== 1'b1) $display("FAIL rst_b_ready got %0h exp 1", b_ready); else pass_cnt++;
        total_cnt++; if (busy_mask !== 32'd0) $display("FAIL rst_busy got %0h exp 0", busy_mask); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL rst_count got %0h exp 0", fifo_count); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total_cnt++; if (we3 !== 1'b0) $display("FAIL idle_we3 got %0h exp 0", we3); else pass_cnt++;
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        tick();
        total_cnt++; if (we3 !== 1'b1) $display("FAIL a_we3 got %0h exp 1", we3); else pass_cnt++;
        total_cnt++; if (a3 !== 5'd5) $display("FAIL a_a3 got %0h exp 5", a3); else pass_cnt++;
        total_cnt++; if (wd3 !== 32'hDEAD_BEEF) $display("FAIL a_wd3 got %0h exp deadbeef", wd3); else pass_cnt++;
        a_valid = 1'b0;
        tick();
        total_cnt++; if (we3 !== 1'b0) $display("FAIL a_off_we3 got %0h exp 0", we3); else pass_cnt++;
        total_cnt++; if (a3 !== 5'd5) $display("FAIL a_hold_a3 got %0h exp 5", a3); else pass_cnt++;
    endtask

    task automatic test_b_contention();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h11;
        tick();
        b_addr = 5'd8; b_data = 32'h22;
        tick();
        b_valid = 1'b0;
        total_cnt++; if (busy_mask !== 32'h180) $display("FAIL bc_busy got %0h exp 180", busy_mask); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd2) $display("FAIL bc_count got %0h exp 2", fifo_count); else pass_cnt++;
        total_cnt++; if (we3 !== 1'b1 || a3 !== 5'd3) $display("FAIL bc_a_wins got we3=%0h a3=%0h exp 1/3", we3, a3); else pass_cnt++;
        a_valid = 1'b0;
        tick();
        total_cnt++; if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h11) $display("FAIL bc_pop1 got %0h/%0h/%0h exp 1/7/11", we3, a3, wd3); else pass_cnt++;
        total_cnt++; if (busy_mask !== 32'h100) $display("FAIL bc_busy1 got %0h exp 100", busy_mask); else pass_cnt++;
        tick();
        total_cnt++; if (we3 !== 1'b1 || a3 !== 5'd8 || wd3 !== 32'h22) $display("FAIL bc_pop2 got %0h/%0h/%0h exp 1/8/22", we3, a3, wd3); else pass_cnt++;
        total_cnt++; if (busy_mask !== 32'h0 || fifo_count !== 3'd0) $display("FAIL bc_empty got busy=%0h cnt=%0h exp 0/0", busy_mask, fifo_count); else pass_cnt++;
        tick();
        total_cnt++; if (we3 !== 1'b0) $display("FAIL bc_idle_we3 got %0h exp 0", we3); else pass_cnt++;
    endtask

    task automatic test_full();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_addr = 5'(10 + i); b_data = 32'hA0 + 32'(i);
            tick();
        end
        total_cnt++; if (fifo_count !== 3'd4) $display("FAIL full_count got %0h exp 4", fifo_count); else pass_cnt++;
        total_cnt++; if (b_ready !== 1'b0) $display("FAIL full_ready got %0h exp 0", b_ready); else pass_cnt++;
        total_cnt++; if (busy_mask !== 32'h3C00) $display("FAIL full_busy got %0h exp 3c00", busy_mask); else pass_cnt++;
        b_addr = 5'd14; b_data = 32'hEE;
        tick();
        total_cnt++; if (fifo_count !== 3'd4 || b_ready !== 1'b0) $display("FAIL full_block got cnt=%0h rdy=%0h exp 4/0", fifo_count, b_ready); else pass_cnt++;
        a_valid = 1'b0;
        tick();
        total_cnt++; if (we3 !== 1'b1 || a3 !== 5'd10 || wd3 !== 32'hA0) $display("FAIL full_pop got %0h/%0h/%0h exp 1/a/a0", we3, a3, wd3); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd3 || b_ready !== 1'b1) $display("FAIL full_release got cnt=%0h rdy=%0h exp 3/1", fifo_count, b_ready); else pass_cnt++;
        b_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            total_cnt++; if (we3 !== 1'b1 || a3 !== 5'(10 + i) || wd3 !== 32'hA0 + 32'(i)) $display("FAIL full_drain%0d got %0h/%0h/%0h exp 1/%0h/%0h", i, we3, a3, wd3, 10 + i, 32'hA0 + 32'(i)); else pass_cnt++;
        end
        tick();
        total_cnt++; if (we3 !== 1'b0 || fifo_count !== 3'd0) $display("FAIL full_no_fifth got we3=%0h cnt=%0h exp 0/0", we3, fifo_count); else pass_cnt++;
    endtask

    task automatic test_waw();
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hAAAA;
        tick();
        total_cnt++; if (busy_mask !== 32'h200) $display("FAIL waw_busy_pre got %0h exp 200", busy_mask); else pass_cnt++;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h5555;
        b_data = 32'hBBBB;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        total_cnt++; if (we3 !== 1'b1 || a3 !== 5'd9 || wd3 !== 32'h5555) $display("FAIL waw_a got %0h/%0h/%0h exp 1/9/5555", we3, a3, wd3); else pass_cnt++;
        total_cnt++; if (busy_mask !== 32'h0) $display("FAIL waw_busy got %0h exp 0", busy_mask); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd2) $display("FAIL waw_count got %0h exp 2", fifo_count); else pass_cnt++;
        tick();
        total_cnt++; if (we3 !== 1'b0 || wd3 !== 32'h5555) $display("FAIL waw_pop1 got we3=%0h wd3=%0h exp 0/5555", we3, wd3); else pass_cnt++;
        tick();
        total_cnt++; if (we3 !== 1'b0 || wd3 !== 32'h5555) $display("FAIL waw_pop2 got we3=%0h wd3=%0h exp 0/5555", we3, wd3); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL waw_empty got %0h exp 0", fifo_count); else pass_cnt++;
    endtask

    task automatic test_reg0();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        tick();
        a_addr = 5'd0; a_data = 32'hFFFF; b_valid = 1'b0;
        tick();
        total_cnt++; if (we3 !== 1'b1 || a3 !== 5'd4 || wd3 !== 32'h44) $display("FAIL r0_pop got %0h/%0h/%0h exp 1/4/44", we3, a3, wd3); else pass_cnt++;
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h99;
        tick();
        b_valid = 1'b0;
        total_cnt++; if (fifo_count !== 3'd0 || busy_mask !== 32'h0) $display("FAIL r0_drop got cnt=%0h busy=%0h exp 0/0", fifo_count, busy_mask); else pass_cnt++;
        total_cnt++; if (we3 !== 1'b0) $display("FAIL r0_we3a got %0h exp 0", we3); else pass_cnt++;
        tick();
        total_cnt++; if (we3 !== 1'b0) $display("FAIL r0_we3b got %0h exp 0", we3); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h66;
        tick();
        b_addr = 5'd12; b_data = 32'hCC;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        total_cnt++; if (fifo_count !== 3'd2 || busy_mask !== 32'h1040) $display("FAIL rm_pre got cnt=%0h busy=%0h exp 2/1040", fifo_count, busy_mask); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (fifo_count !== 3'd0 || busy_mask !== 32'h0 || we3 !== 1'b0) $display("FAIL rm_clear got cnt=%0h busy=%0h we3=%0h exp 0/0/0", fifo_count, busy_mask, we3); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++; if (we3 !== 1'b0) $display("FAIL rm_no_write1 got %0h exp 0", we3); else pass_cnt++;
        tick();
        total_cnt++; if (we3 !== 1'b0) $display("FAIL rm_no_write2 got %0h exp 0", we3); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_contention();
        test_full();
        test_waw();
        test_reg0();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer-side front end for the 32x32 pipeline register file write port (WE3/A3/WD3).
- Merges two write sources into the single port:
  - Source A: the in-order writeback stage. It cannot stall and always has priority.
  - Source B: multicycle units (mul/div, late loads). These use a valid/ready handshake and are buffered in a DEPTH-entry FIFO.
- Supplies a pending-write mask to the hazard unit.
- Outputs are registered on posedge clk, so the register file commits them at the following negedge.

Parameters:
- DEPTH, 4, number of source-B FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  source A write request this cycle.
- a_addr  input  5  source A destination register.
- a_data  input  32  source A write data.
- b_valid  input  1  source B write request.
- b_ready  output  1  FIFO can accept; equals !full, from registered count.
- b_addr  input  5  source B destination register.
- b_data  input  32  source B write data.
- we3  output  1  register file write enable (drives WE3).
- a3  output  5  register file write address (drives A3).
- wd3  output  32  register file write data (drives WD3).
- busy_mask  output  32  bit r = 1 iff a live FIFO entry targets register r.
- fifo_count  output  PTR_W+1  number of occupied FIFO entries, live or squashed.

Behaviour:
- Reset (async, rst_n=0):
  - we3=0, a3=0, wd3=0.
  - FIFO empty: count=0, pointers=0, all live bits 0.
  - b_ready=1, busy_mask=0, fifo_count=0.
  - Deassertion takes effect at the next posedge.
  - Reset mid-operation discards all queued entries; no write is issued for them.
- FIFO entry = {live, addr[4:0], data[31:0]}.
- Enqueue:
  - Occurs when b_valid && b_ready at posedge.
  - b_addr==0 is accepted and dropped: no entry, count unchanged.
- Arbitration at each posedge, in priority order:
  1. a_valid && a_addr!=0: register we3=1, a3=a_addr, wd3=a_data. No FIFO pop.
  2. Otherwise, FIFO non-empty: pop head. If head.live: we3=1, a3=head.addr, wd3=head.data. If head is squashed: we3=0, a3/wd3 hold previous values.
  3. Otherwise: we3=0, a3/wd3 hold previous values.
- a_valid with a_addr==0 counts as idle; the FIFO may pop that cycle.
- Latency:
  - A: request at posedge N appears on we3/a3/wd3 after posedge N; register file writes at the negedge of cycle N.
  - B: minimum 2 posedges from handshake to we3, i.e. enqueue at edge N, pop at edge N+1.
  - No bypass from b inputs to the outputs.
- WAW squash (A is newer than any B result):
  - When A writes register X (rule 1), every live FIFO entry with addr==X is cleared to live=0 at the same edge.
  - A B entry enqueued at the same edge with b_addr==X is written with live=0.
  - Squashed entries still occupy slots until popped.
- Two B entries to the same register are both kept and written in FIFO order, so the last enqueued value wins.
- Simultaneous enqueue and pop: both occur; count is unchanged.
- Full: b_ready=0 whenever count==DEPTH, even if a pop occurs that edge. No enqueue while full.
- Starvation: B drains only in cycles with no valid A write. There is no fairness guarantee; the hazard unit must stall using busy_mask.
- busy_mask is combinational from the FIFO state: OR over live entries of a one-hot decode of addr. Bit 0 is always 0.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle → we3=0, b_ready=1, busy_mask=0 immediately. After release with no requests → we3 stays 0.
- A only: a_valid=1, a_addr=5, a_data=32'hDEAD_BEEF at edge N → after edge N: we3=1, a3=5, wd3=DEADBEEF. Next cycle with a_valid=0 → we3=0.
- B drain with A contention:
  - Enqueue B(7,0x11), B(8,0x22) on consecutive edges while A writes reg 3 each cycle → both held; busy_mask=0x180.
  - Drop A → writes 7/0x11 then 8/0x22 on consecutive cycles; busy_mask returns to 0.
- Full/backpressure: with A busy, enqueue 4 B entries → fifo_count=4, b_ready=0; 5th b_valid not accepted. Release A for one cycle → pop; b_ready=1 next cycle.
- WAW squash: queue B(9,0xAAAA). Then A writes reg 9 with 0x5555 at the same edge as a new B(9,0xBBBB) enqueue → busy_mask bit9=0. FIFO pops 2 entries with we3=0. The final register 9 write seen is 0x5555.
- Register 0: a_addr=0 with FIFO holding B(4,0x44) → a3=4, wd3=0x44, we3=1. Enqueuing B(0,x) → fifo_count unchanged, no write ever issued.
